// File: rtl/clk_div_prog.sv
// clk_div_prog: run-time programmable clock divider with registered
// output, per-period tick, and glitch-free divisor updates.
module clk_div_prog #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] div_in,
  output logic             clk_out,
  output logic             tick,
  output logic             upd_pending,
  output logic             div_err
);

  if (DEFAULT_DIV < 2 || DEFAULT_DIV > (2**WIDTH) - 1) begin : g_bad_div
    $error("clk_div_prog: DEFAULT_DIV out of range");
  end

  localparam logic [WIDTH-1:0] DefDiv = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] One    = WIDTH'(1);

  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;
  logic [WIDTH:0]   h_new;
  logic             load_ok;

  assign load_ok = load && (div_in > One);

  always_comb begin
    d_d    = d_q;
    p_d    = p_q;
    pend_d = pend_q;
    cnt_d  = cnt_q;
    clk_d  = clk_q;
    tick_d = 1'b0;
    h_new  = '0;
    if (en) begin
      if (cnt_q == d_q - One) begin
        cnt_d = '0;
        if (pend_q) begin
          d_d    = p_q;
          pend_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + One;
      end
      // one bit wider so ceil(D/2) cannot overflow at D = 2^WIDTH-1
      h_new  = ({1'b0, d_d} + (WIDTH+1)'(1)) >> 1;
      clk_d  = ({1'b0, cnt_d} < h_new);
      tick_d = (cnt_d == '0);
    end
    // a load on a boundary edge stages for the following boundary
    if (load_ok) begin
      p_d    = div_in;
      pend_d = 1'b1;
    end
    err_d = load && !load_ok;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d_q    <= DefDiv;
      p_q    <= '0;
      cnt_q  <= '0;
      pend_q <= 1'b0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      d_q    <= d_d;
      p_q    <= p_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
      err_q  <= err_d;
    end
  end

  assign clk_out     = clk_q;
  assign tick        = tick_q;
  assign upd_pending = pend_q;
  assign div_err     = err_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: scoreboard bench for clk_div_prog; expected outputs
// queued per edge, a monitor compares, plus hand-computed period checks.
module tb_clk_div_prog;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] div_in = '0;
  logic         clk_out, tick, upd_pending, div_err;

  always #5 clk = ~clk;

  clk_div_prog #(.WIDTH(W), .DEFAULT_DIV(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .load       (load),
    .div_in     (div_in),
    .clk_out    (clk_out),
    .tick       (tick),
    .upd_pending(upd_pending),
    .div_err    (div_err)
  );

  typedef struct packed {
    logic c;
    logic t;
    logic u;
    logic e;
  } obs_t;

  obs_t exp_q[$];
  obs_t mon_a, mon_x;
  int   n_cmp = 0;
  int   n_bad = 0;

  int   m_d = 4, m_cnt = 0, m_p = 0;
  bit   m_pend = 0, m_clk = 0, m_tick = 0, m_err = 0;
  logic obs_clk, obs_tick;

  function automatic void model(bit r, bit e, bit l, int v);
    if (r) begin
      m_d = 4; m_cnt = 0; m_p = 0; m_pend = 0;
      m_clk = 0; m_tick = 0; m_err = 0;
      return;
    end
    if (e) begin
      if (m_cnt == m_d - 1) begin
        m_cnt = 0;
        if (m_pend) begin
          m_d = m_p;
          m_pend = 0;
        end
      end else begin
        m_cnt++;
      end
      m_clk  = (m_cnt < (m_d + 1) / 2);
      m_tick = (m_cnt == 0);
    end else begin
      m_tick = 0;
    end
    m_err = l && (v < 2);
    if (l && v >= 2) begin
      m_p = v;
      m_pend = 1;
    end
  endfunction

  task automatic cyc(input bit r, input bit e, input bit l, input int v);
    @(negedge clk);
    obs_clk  = clk_out;
    obs_tick = tick;
    reset  = r;
    en     = e;
    load   = l;
    div_in = v[W-1:0];
    model(r, e, l, v);
    exp_q.push_back('{c: m_clk, t: m_tick, u: m_pend, e: m_err});
  endtask

  task automatic chk(input string nm, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  // counts high/low edges of one full output period, tick to tick
  task automatic measure(input int eh, input int el, input string nm);
    int hi, lo, n;
    hi = 0; lo = 0; n = 0;
    cyc(0, 1, 0, 0);
    while (!obs_tick && n < 1000) begin
      cyc(0, 1, 0, 0);
      n++;
    end
    do begin
      if (obs_clk) hi++;
      else lo++;
      cyc(0, 1, 0, 0);
      n++;
    end while (!obs_tick && n < 1000);
    chk({nm, " high"}, hi, eh);
    chk({nm, " low"}, lo, el);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_x = exp_q.pop_front();
        mon_a = {clk_out, tick, upd_pending, div_err};
        n_cmp++;
        if (mon_a !== mon_x) begin
          n_bad++;
          $display("FAIL outputs t=%0t {clk_out,tick,upd,err}: got %b, want %b",
                   $time, mon_a, mon_x);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    repeat (12) cyc(0, 1, 0, 0);
    measure(2, 2, "d4");

    cyc(0, 1, 1, 1);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 0, 0);
    measure(2, 2, "bad_load");

    repeat (3) cyc(0, 0, 0, 0);
    repeat (9) cyc(0, 1, 0, 0);
    measure(2, 2, "after_en");

    cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 5);
    measure(3, 2, "d5a");
    measure(3, 2, "d5b");

    cyc(0, 1, 1, 4);
    measure(2, 2, "back4");

    cyc(0, 1, 1, 5);
    for (int i = 0; i < 10 && m_cnt != m_d - 1; i++) cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 6);
    measure(3, 2, "chain5");
    measure(3, 3, "chain6");

    cyc(0, 1, 1, 255);
    measure(128, 127, "d255");
    repeat (20) cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 7);
    cyc(1, 1, 0, 0);
    repeat (10) cyc(0, 1, 0, 0);
    measure(2, 2, "post_reset");

    @(negedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
